// File: rtl/regfile_arbiter.sv
// Sequencing front-end for the register file's single read and write ports:
// round-robin over two readers, write-before-read on index match, r0 short-circuit, handshake timeout.
module regfile_arbiter #(
  parameter int REG_SZ  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rd_req,
  input  logic [4:0]        rd_idx0,
  input  logic [4:0]        rd_idx1,
  output logic [1:0]        rd_valid,
  output logic [REG_SZ-1:0] rd_data,
  input  logic              wr_req,
  input  logic [4:0]        wr_idx,
  input  logic [REG_SZ-1:0] wr_data,
  output logic              wr_done,
  output logic              err,
  output logic              rf_re,
  output logic              rf_we,
  output logic [4:0]        rf_r_idx,
  output logic [4:0]        rf_w_idx,
  output logic [REG_SZ-1:0] rf_din,
  input  logic              rf_rack,
  input  logic              rf_wack,
  input  logic [REG_SZ-1:0] rf_dout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_REL} w_state_t;

  r_state_t          r_st, r_nxt;
  w_state_t          w_st, w_nxt;
  logic              rack_m, rack_s, wack_m, wack_s;
  logic [CW-1:0]     r_cnt, r_cnt_nxt, w_cnt, w_cnt_nxt;
  logic              rr, rr_nxt, r_gnt, r_gnt_nxt;
  logic              r_err, w_err;
  logic [1:0]        elig;
  logic              gsel;
  logic [4:0]        g_idx;
  logic [1:0]        rd_valid_nxt;
  logic [REG_SZ-1:0] rd_data_nxt, rf_din_nxt;
  logic              rf_re_nxt, rf_we_nxt, wr_done_nxt;
  logic [4:0]        rf_r_idx_nxt, rf_w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rack_m <= 1'b0;
      rack_s <= 1'b0;
      wack_m <= 1'b0;
      wack_s <= 1'b0;
    end else begin
      rack_m <= rf_rack;
      rack_s <= rack_m;
      wack_m <= rf_wack;
      wack_s <= wack_m;
    end
  end

  // A pending or in-flight write to the same index blocks the read until W_IDLE.
  always_comb begin
    elig = '0;
    if (w_st == W_IDLE) begin
      elig[0] = rd_req[0] && !(wr_req && (wr_idx == rd_idx0));
      elig[1] = rd_req[1] && !(wr_req && (wr_idx == rd_idx1));
    end else begin
      elig[0] = rd_req[0] && (rf_w_idx != rd_idx0);
      elig[1] = rd_req[1] && (rf_w_idx != rd_idx1);
    end
    gsel  = (elig == 2'b11) ? rr : elig[1];
    g_idx = gsel ? rd_idx1 : rd_idx0;
  end

  always_comb begin
    r_nxt        = r_st;
    r_cnt_nxt    = r_cnt;
    rr_nxt       = rr;
    r_gnt_nxt    = r_gnt;
    rf_re_nxt    = rf_re;
    rf_r_idx_nxt = rf_r_idx;
    rd_valid_nxt = '0;
    rd_data_nxt  = rd_data;
    r_err        = 1'b0;
    case (r_st)
      R_IDLE: begin
        if ((elig != 2'b00) && !rack_s) begin
          rr_nxt = ~gsel;
          if (g_idx == '0) begin
            rd_valid_nxt[gsel] = 1'b1;
            rd_data_nxt        = '0;
          end else begin
            r_nxt        = R_REQ;
            r_cnt_nxt    = '0;
            r_gnt_nxt    = gsel;
            rf_re_nxt    = 1'b1;
            rf_r_idx_nxt = g_idx;
          end
        end
      end
      R_REQ: begin
        if (rack_s) begin
          r_nxt               = R_REL;
          r_cnt_nxt           = '0;
          rf_re_nxt           = 1'b0;
          rd_data_nxt         = rf_dout;
          rd_valid_nxt[r_gnt] = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          r_nxt               = R_IDLE;
          r_cnt_nxt           = '0;
          rf_re_nxt           = 1'b0;
          rd_data_nxt         = '0;
          rd_valid_nxt[r_gnt] = 1'b1;
          r_err               = 1'b1;
        end else begin
          r_cnt_nxt = r_cnt + CW'(1);
        end
      end
      R_REL: begin
        if (!rack_s) begin
          r_nxt     = R_IDLE;
          r_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          r_nxt     = R_IDLE;
          r_cnt_nxt = '0;
          r_err     = 1'b1;
        end else begin
          r_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_nxt        = w_st;
    w_cnt_nxt    = w_cnt;
    rf_we_nxt    = rf_we;
    rf_w_idx_nxt = rf_w_idx;
    rf_din_nxt   = rf_din;
    wr_done_nxt  = 1'b0;
    w_err        = 1'b0;
    case (w_st)
      W_IDLE: begin
        if (wr_req && !wack_s) begin
          if (wr_idx == '0) begin
            wr_done_nxt = 1'b1;
          end else begin
            w_nxt        = W_REQ;
            w_cnt_nxt    = '0;
            rf_we_nxt    = 1'b1;
            rf_w_idx_nxt = wr_idx;
            rf_din_nxt   = wr_data;
          end
        end
      end
      W_REQ: begin
        if (wack_s) begin
          w_nxt       = W_REL;
          w_cnt_nxt   = '0;
          rf_we_nxt   = 1'b0;
          wr_done_nxt = 1'b1;
        end else if (w_cnt == CNT_LAST) begin
          w_nxt       = W_IDLE;
          w_cnt_nxt   = '0;
          rf_we_nxt   = 1'b0;
          wr_done_nxt = 1'b1;
          w_err       = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt + CW'(1);
        end
      end
      W_REL: begin
        if (!wack_s) begin
          w_nxt     = W_IDLE;
          w_cnt_nxt = '0;
        end else if (w_cnt == CNT_LAST) begin
          w_nxt     = W_IDLE;
          w_cnt_nxt = '0;
          w_err     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt + CW'(1);
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= R_IDLE;
      w_st     <= W_IDLE;
      r_cnt    <= '0;
      w_cnt    <= '0;
      rr       <= 1'b0;
      r_gnt    <= 1'b0;
      rf_re    <= 1'b0;
      rf_we    <= 1'b0;
      rf_r_idx <= '0;
      rf_w_idx <= '0;
      rf_din   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      wr_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_st     <= r_nxt;
      w_st     <= w_nxt;
      r_cnt    <= r_cnt_nxt;
      w_cnt    <= w_cnt_nxt;
      rr       <= rr_nxt;
      r_gnt    <= r_gnt_nxt;
      rf_re    <= rf_re_nxt;
      rf_we    <= rf_we_nxt;
      rf_r_idx <= rf_r_idx_nxt;
      rf_w_idx <= rf_w_idx_nxt;
      rf_din   <= rf_din_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
      wr_done  <= wr_done_nxt;
      err      <= err | r_err | w_err;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a behavioural register file with delayed,
// clock-unaligned acks, and a scoreboard of expected read/write completions.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_req;
  logic [4:0]  rd_idx0, rd_idx1;
  logic [1:0]  rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        wr_done, err;
  logic        rf_re, rf_we;
  logic [4:0]  rf_r_idx, rf_w_idx;
  logic [31:0] rf_din;
  logic        rf_rack, rf_wack;
  logic [31:0] rf_dout;

  regfile_arbiter #(.REG_SZ(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_idx0(rd_idx0), .rd_idx1(rd_idx1),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_done(wr_done),
    .err(err),
    .rf_re(rf_re), .rf_we(rf_we), .rf_r_idx(rf_r_idx), .rf_w_idx(rf_w_idx),
    .rf_din(rf_din), .rf_rack(rf_rack), .rf_wack(rf_wack), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // Register file: acks follow the strobes 2 ns later, independent of clk.
  logic [31:0] mem [32];
  logic        tie_rack = 1'b0;

  always @(rf_we) begin
    #2;
    if (rf_we === 1'b1) begin
      mem[rf_w_idx] = rf_din;
      rf_wack = 1'b1;
    end else begin
      rf_wack = 1'b0;
    end
  end

  always @(rf_re) begin
    #2;
    if (rf_re === 1'b1) begin
      if (!tie_rack) begin
        rf_dout = mem[rf_r_idx];
        rf_rack = 1'b1;
      end
    end else begin
      rf_rack = 1'b0;
    end
  end

  int re_cnt = 0, we_cnt = 0, done_cnt = 0;
  always @(posedge rf_re)   re_cnt++;
  always @(posedge rf_we)   we_cnt++;
  always @(posedge wr_done) done_cnt++;

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
    int unsigned lat;
  } rexp_t;

  rexp_t       rd_q[$];
  int unsigned wr_q[$];
  logic [31:0] ref_rf [32];
  int total = 0, bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    int unsigned n = 0;
    rexp_t e;
    while (rd_valid === 2'b00 && n < 40) begin
      step();
      n++;
    end
    total++;
    assert (rd_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_q observed=empty expected=entry", tag);
    end
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_valid"}, {30'd0, rd_valid}, {30'd0, e.v});
      check({tag, "_data"}, rd_data, e.d);
    end
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    int unsigned lat;
    while (wr_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    assert (wr_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_q observed=empty expected=entry", tag);
    end
    if (wr_q.size() > 0) begin
      lat = wr_q.pop_front();
      check({tag, "_lat"}, n, lat);
      check({tag, "_done"}, {31'd0, wr_done}, 32'd1);
    end
  endtask

  task automatic wait_re(input string tag, input int unsigned exp_n);
    int unsigned n = 0;
    while (rf_re !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_wait"}, n, exp_n);
  endtask

  task automatic push_rd(input logic [1:0] v, input logic [31:0] d, input int unsigned lat);
    rexp_t e;
    e.v = v;
    e.d = d;
    e.lat = lat;
    rd_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int re0, we0, dc0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 32'hA500_0000 | i;
      ref_rf[i] = 32'hA500_0000 | i;
    end
    ref_rf[0] = '0;
    mem[7] = 32'h22;  ref_rf[7] = 32'h22;
    rf_rack = 1'b0; rf_wack = 1'b0; rf_dout = 32'h0BAD_0BAD;
    rst_n = 1'b0; rd_req = '0; rd_idx0 = '0; rd_idx1 = '0;
    wr_req = 1'b0; wr_idx = '0; wr_data = '0;

    #3;
    check("rst_rd_valid", {30'd0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wr_done", {31'd0, wr_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_strobes", {30'd0, rf_re, rf_we}, 32'd0);
    check("rst_idx_din", rf_din | {27'd0, rf_r_idx} | {27'd0, rf_w_idx}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Both readers together after reset: requester 0 first, requester 1 at E7.
    rd_req = 2'b11; rd_idx0 = 5'd3; rd_idx1 = 5'd4;
    push_rd(2'b01, ref_rf[3], 3);
    push_rd(2'b10, ref_rf[4], 3);
    step();
    check("rr0_re", {31'd0, rf_re}, 32'd1);
    check("rr0_idx", {27'd0, rf_r_idx}, 32'd3);
    wait_rd("rr0_first");
    rd_req = 2'b10;
    wait_re("rr0_second", 4);
    check("rr0_idx2", {27'd0, rf_r_idx}, 32'd4);
    wait_rd("rr0_second");
    rd_req = 2'b00;
    step(); step(); step(); step();

    // Write idx 5, then requester 0 reads it back.
    wr_req = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEAD_BEEF;
    ref_rf[5] = 32'hDEAD_BEEF;
    wr_q.push_back(3);
    step();
    check("w5_we", {31'd0, rf_we}, 32'd1);
    check("w5_idx", {27'd0, rf_w_idx}, 32'd5);
    check("w5_din", rf_din, 32'hDEAD_BEEF);
    wait_done("w5");
    wr_req = 1'b0;
    rd_req = 2'b01; rd_idx0 = 5'd5;
    push_rd(2'b01, ref_rf[5], 3);
    wait_re("r5", 4);
    wait_rd("r5");

    // Repeat both readers: pointer now favours requester 1.
    rd_req = 2'b11; rd_idx0 = 5'd3; rd_idx1 = 5'd4;
    push_rd(2'b10, ref_rf[4], 3);
    push_rd(2'b01, ref_rf[3], 3);
    wait_re("rr1_first", 4);
    check("rr1_idx", {27'd0, rf_r_idx}, 32'd4);
    wait_rd("rr1_first");
    rd_req = 2'b01;
    wait_re("rr1_second", 4);
    check("rr1_idx2", {27'd0, rf_r_idx}, 32'd3);
    wait_rd("rr1_second");
    rd_req = 2'b00;
    step(); step(); step(); step();

    // Same-edge write and read of idx 7: the read must see the new value.
    wr_req = 1'b1; wr_idx = 5'd7; wr_data = 32'h11;
    rd_req = 2'b01; rd_idx0 = 5'd7;
    ref_rf[7] = 32'h11;
    wr_q.push_back(3);
    push_rd(2'b01, ref_rf[7], 3);
    step();
    check("w7_we", {31'd0, rf_we}, 32'd1);
    check("w7_re_stall", {31'd0, rf_re}, 32'd0);
    wait_done("w7");
    wr_req = 1'b0;
    wait_re("r7", 4);
    check("r7_idx", {27'd0, rf_r_idx}, 32'd7);
    wait_rd("r7");
    rd_req = 2'b00;
    step(); step(); step(); step();

    // Index 0 never touches the register file.
    re0 = re_cnt; we0 = we_cnt;
    wr_req = 1'b1; wr_idx = 5'd0; wr_data = 32'hFF;
    wr_q.push_back(0);
    step();
    wait_done("w0");
    wr_req = 1'b0;
    rd_req = 2'b01; rd_idx0 = 5'd0;
    push_rd(2'b01, 32'd0, 0);
    step();
    check("w0_pulse_len", {31'd0, wr_done}, 32'd0);
    wait_rd("r0");
    rd_req = 2'b00;
    step();
    rd_req = 2'b11; rd_idx0 = 5'd0; rd_idx1 = 5'd0;
    push_rd(2'b10, 32'd0, 0);
    step();
    wait_rd("r0_both_a");
    rd_req = 2'b01;
    push_rd(2'b01, 32'd0, 0);
    step();
    wait_rd("r0_both_b");
    rd_req = 2'b00;
    step();
    check("r0_no_re", re_cnt - re0, 32'd0);
    check("r0_no_we", we_cnt - we0, 32'd0);

    // Read handshake that never acks: aborts after 8 cycles in R_REQ.
    tie_rack = 1'b1;
    rd_req = 2'b01; rd_idx0 = 5'd9;
    push_rd(2'b01, 32'd0, 8);
    step();
    check("to_re", {31'd0, rf_re}, 32'd1);
    wait_rd("to");
    check("to_re_drop", {31'd0, rf_re}, 32'd0);
    check("to_err", {31'd0, err}, 32'd1);
    rd_req = 2'b00;
    tie_rack = 1'b0;
    step(); step(); step(); step(); step();
    check("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset asserted at E1 of a write.
    wr_req = 1'b1; wr_idx = 5'd12; wr_data = 32'hCAFE;
    step();
    step();
    dc0 = done_cnt;
    rst_n = 1'b0;
    wr_req = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_out", rf_din | {27'd0, rf_w_idx} | {30'd0, rd_valid} | {31'd0, wr_done}, 32'd0);
    step(); step(); step();
    check("mid_rst_no_done", done_cnt - dc0, 32'd0);
    rst_n = 1'b1;
    step();
    wr_req = 1'b1; wr_idx = 5'd12; wr_data = 32'hBEEF;
    ref_rf[12] = 32'hBEEF;
    wr_q.push_back(3);
    step();
    check("w12_we", {31'd0, rf_we}, 32'd1);
    wait_done("w12");
    wr_req = 1'b0;
    rd_req = 2'b10; rd_idx1 = 5'd12;
    push_rd(2'b10, ref_rf[12], 3);
    wait_re("r12", 4);
    wait_rd("r12");
    rd_req = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencing front-end for the register file's single read port and single write port. It accepts register reads from two requesters (decode-stage rs and rt) and writes from writeback. It drives the register file's level-sensitive re/rack and we/wack handshakes, enforces write-before-read ordering on the same index, short-circuits register 0, and flags hung handshakes with a timeout. It sits between the pipeline control and the register file.

## Interface
- REG_SZ, 32, data width
- TIMEOUT, 64, max cycles an rf handshake phase may take before abort
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_req  in  2  per-requester read request (level)
- rd_idx0, rd_idx1  in  5 each  register index for requester 0 / 1
- rd_valid  out  2  one-cycle pulse: rd_data valid for that requester
- rd_data  out  REG_SZ  read result, shared by both requesters
- wr_req  in  1  write request (level)
- wr_idx  in  5  write index
- wr_data  in  REG_SZ  write data
- wr_done  out  1  one-cycle pulse: write finished
- err  out  1  sticky timeout flag
- rf_re, rf_we  out  1  read/write strobes to the register file
- rf_r_idx, rf_w_idx  out  5  indices to the register file
- rf_din  out  REG_SZ  write data to the register file
- rf_rack, rf_wack  in  1  acks from the register file (edge-generated, not clk-aligned)
- rf_dout  in  REG_SZ  read data from the register file

## Operation
- rf_rack and rf_wack each pass through a 2-flop synchronizer (rack_s, wack_s), reset to 0.
- Read FSM states and transitions:
  - R_IDLE → R_REQ: an eligible request is granted; rf_r_idx is latched and rf_re=1.
  - R_REQ → R_REL: on rack_s=1; rd_data←rf_dout, pulse rd_valid[g], rf_re=0.
  - R_REL → R_IDLE: on rack_s=0.
- Write FSM states and transitions:
  - W_IDLE → W_REQ: wr_req granted; rf_w_idx and rf_din are latched and rf_we=1.
  - W_REQ → W_REL: on wack_s=1; pulse wr_done, rf_we=0.
  - W_REL → W_IDLE: on wack_s=0.
- Read and write FSMs run concurrently.
- An IDLE state accepts a request only while its own synced ack is 0.
- Read eligibility: rd_req[i]=1, and the write FSM is either idle with no same-index wr_req, or its in-flight index differs from rd_idx_i.
  - Write has priority on an index match; the read stalls until W_IDLE.
- Arbitration is round-robin between the two readers.
  - rr pointer resets to requester 0.
  - After each read grant, the pointer moves to the other requester.
  - A sole eligible requester wins regardless of the pointer.
- Index 0 reads: no rf access. Stay in R_IDLE, pulse rd_valid[i] with rd_data=0 on the grant edge. The rr pointer still toggles.
- Index 0 writes: no rf access. Pulse wr_done on the grant edge, stay in W_IDLE.
- Timeout counter: per FSM, cleared on entry to REQ and to REL, incremented each cycle in REQ/REL.
  - When the count reaches TIMEOUT: set err, drop the strobe, return to IDLE.
  - A timeout in REQ also pulses rd_valid with rd_data=0, or pulses wr_done.
  - err is cleared only by reset.
- Requester contract: hold req and idx/data stable until the valid/done pulse, and deassert req in the next cycle. A req still high after that is treated as a new request.

## Timing
- Reset values: all outputs 0, FSMs IDLE, synchronizers 0, counters 0, rr=0.
  - Reset mid-transaction drops rf_re/rf_we immediately; no valid/done pulse is issued.
- Edge numbering: E0 is the accepting edge.
- rf-backed read or write:
  - After E0: strobe=1.
  - After E3: valid/done pulse, strobe=0 (synchronizer latency 2 plus 1).
  - At E6: FSM returns to IDLE.
  - At E7: earliest next accept. Sustained rate is 1 per 7 cycles per port.
- Index 0 access: pulse after E0; next accept at E1.
- Simultaneous read and write to the same nonzero index at E0: write accepted, read accepted at the edge after W_IDLE is re-entered, so the read returns the new data.

## Test plan
- Reset, then write idx 5 = 0xDEADBEEF, then requester 0 reads idx 5 → rf_we after E0; wr_done after E3; read returns 0xDEADBEEF, rd_valid=2'b01 three edges after its accept.
- Both readers request at the same edge (idx 3, idx 4) → requester 0 served first, requester 1 accepted at E7. Repeat both: requester 1 first.
- Write idx 7 = 0x11 and read idx 7 at the same edge (old value 0x22) → read returns 0x11; read accepted only after W_IDLE.
- Read idx 0 after writing idx 0 = 0xFF → rd_valid after E0 with rd_data=0; rf_re and rf_we never asserted.
- rf_rack tied 0, TIMEOUT=8 → rf_re drops after 8 cycles in R_REQ; rd_valid pulses with 0; err=1 and stays 1 until rst_n low.
- rst_n pulled low at E1 of a write → rf_we=0 and all outputs 0 asynchronously; no wr_done; a new request after release completes normally.
